des_decrypt_core: RTL and testbench

DES_DECRYPT_CORE -- requirements
Module: des_decrypt_core

---
 rtl/des_pkg.sv | 149 ++++++++++++++
 rtl/des_f.sv | 23 ++
 rtl/des_decrypt_core.sv | 91 +++++++++
 tb/tb_des_decrypt_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants (permutation tables, S-boxes, key shift schedule) and
// the permutation helpers used by both the round function and the core.
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  // Tables hold DES bit numbers, 1 = most significant bit of the source word.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_TBL [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};

  // Encryption left-shift schedule for rounds 1..16.
  localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each box stored row-major: entry = row*16 + column.
  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
    return y;
  endfunction

  // Outer bits of the 6-bit group select the row, inner four the column.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] six);
    return 4'(SBOX[n][{six[5], six[0], six[4:1]}]);
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K): expand, key mix, S-box substitution, permute.
// Purely combinational so the encrypt core can share it.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] f
);

  logic [47:0] mixed;
  logic [31:0] sout;

  always_comb begin
    mixed = e_expand(r) ^ subkey;
    sout  = '0;
    for (int s = 0; s < 8; s++) begin
      sout[5'(28 - 4 * s) +: 4] = sbox_lookup(3'(s), mixed[6'(42 - 6 * s) +: 6]);
    end
    f = p_perm(sout);
  end

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1
// generated on the fly by right-rotating the PC1 halves.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] message,
  input  logic [63:0] DESkey,
  input  logic        enable,
  input  logic        ack,
  output logic [63:0] decrypted,
  output logic        done,
  output logic        busy
);

  state_t      state, state_next;
  logic [4:0]  round;
  logic [31:0] l, r;
  logic [27:0] c, d;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [1:0]  shift;

  assign subkey = pc2_perm({c, d});
  // After round n the halves move back by the encrypt shift of round 17-n.
  assign shift  = 2'(SHIFT_SCHED[4'(5'd16 - round)]);

  des_f u_f (
    .r      (r),
    .subkey (subkey),
    .f      (f_out)
  );

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = ROUND;
      ROUND:   if (round == 5'd16) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round     <= '0;
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      decrypted <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            {l, r} <= ip_perm(message);
            {c, d} <= pc1_perm(DESkey);
            round  <= 5'd1;
          end
        end
        ROUND: begin
          l <= r;
          r <= l ^ f_out;
          if (round != 5'd16) begin
            c     <= ror28(c, shift);
            d     <= ror28(d, shift);
            round <= round + 5'd1;
          end
        end
        // Halves are swapped back before the final permutation.
        FINAL:   decrypted <= fp_perm({r, l});
        default: ;
      endcase
    end
  end

  assign done = (state == DONE);
  assign busy = (state == ROUND) || (state == FINAL);

endmodule

// File: tb/tb_des_decrypt_core.sv
// Bench for des_decrypt_core: known-answer table, handshake/abort sequences,
// and randomized round-trips against a whole-block DES model.
module tb_des_decrypt_core;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] message;
  logic [63:0] DESkey;
  logic        enable;
  logic        ack;
  logic [63:0] decrypted;
  logic        done;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  des_decrypt_core dut (
    .clk       (clk),
    .reset     (reset),
    .message   (message),
    .DESkey    (DESkey),
    .enable    (enable),
    .ack       (ack),
    .decrypted (decrypted),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] msg;
    logic [63:0] key;
    logic [63:0] exp;
  } vec_t;

  // ---------------- reference model ----------------
  function automatic int tab(input int sel, input int i);
    case (sel)
      0:       return IP_TBL[i];
      1:       return FP_TBL[i];
      2:       return E_TBL[i];
      3:       return P_TBL[i];
      4:       return PC1_TBL[i];
      default: return PC2_TBL[i];
    endcase
  endfunction

  // Right-aligned in_w-bit word in, right-aligned out_w-bit word out.
  function automatic logic [63:0] tperm(input logic [63:0] x, input int in_w,
                                        input int out_w, input int sel);
    logic [63:0] y;
    y = '0;
    for (int k = 0; k < out_w; k++)
      y = (y << 1) | ((x >> (in_w - tab(sel, k))) & 64'd1);
    return y;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] rr, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    int six, row, col;
    e = 48'(tperm({32'd0, rr}, 32, 48, 2)) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      six = int'((e >> (42 - 6 * i)) & 48'h3f);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s   = (s << 4) | 32'(SBOX[i][row * 16 + col]);
    end
    return 32'(tperm({32'd0, s}, 32, 32, 3));
  endfunction

  function automatic logic [63:0] m_des(input logic [63:0] blk, input logic [63:0] key,
                                        input bit decrypt);
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] cc, dd;
    logic [63:0] t;
    logic [31:0] ll, rr, tmp;
    cd = 56'(tperm(key, 64, 56, 4));
    cc = cd[55:28];
    dd = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      cc    = (cc << SHIFT_SCHED[i]) | (cc >> (28 - SHIFT_SCHED[i]));
      dd    = (dd << SHIFT_SCHED[i]) | (dd >> (28 - SHIFT_SCHED[i]));
      ks[i] = 48'(tperm({8'd0, cc, dd}, 56, 48, 5));
    end
    t  = tperm(blk, 64, 64, 0);
    ll = t[63:32];
    rr = t[31:0];
    for (int i = 0; i < 16; i++) begin
      tmp = rr;
      rr  = ll ^ m_f(rr, ks[decrypt ? 15 - i : i]);
      ll  = tmp;
    end
    return tperm({rr, ll}, 64, 64, 1);
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [63:0] msg, input logic [63:0] key, input bit scramble,
                           output logic [63:0] res, output int lat);
    message = msg;
    DESkey  = key;
    enable  = 1'b1;
    tick();
    enable = 1'b0;
    check("busy_after_capture", 64'(busy), 64'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (scramble) begin
        message = {$urandom, $urandom};
        DESkey  = {$urandom, $urandom};
        enable  = 1'($urandom);
        ack     = 1'($urandom);
      end
      tick();
      lat++;
    end
    enable = 1'b0;
    ack    = 1'b0;
    res    = decrypted;
  endtask

  task automatic release_done();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("done_after_ack", 64'(done), 64'd0);
  endtask

  task automatic block_and_check(input string name, input logic [63:0] msg,
                                 input logic [63:0] key, input logic [63:0] exp,
                                 input bit scramble);
    logic [63:0] res;
    int lat;
    run_block(msg, key, scramble, res, lat);
    check({name, "_latency"}, 64'(lat), 64'd17);
    check({name, "_data"}, res, exp);
    release_done();
  endtask

  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;

  initial begin
    vec_t        vecs [5];
    logic [63:0] held, res, pt, key, ct;
    int          lat;

    vecs[0] = '{KAT_CT, KAT_KEY, KAT_PT};
    vecs[1] = '{64'h8CA64DE9C1B123A7, 64'h0000000000000000, 64'h0000000000000000};
    vecs[2] = '{64'h8CA64DE9C1B123A7, 64'h0101010101010101, 64'h0000000000000000};
    vecs[3] = '{64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{64'h7359B2163E4EDC58, 64'hFEFEFEFEFEFEFEFE, 64'hFFFFFFFFFFFFFFFF};

    reset = 1'b0; message = '0; DESkey = '0; enable = 1'b0; ack = 1'b0;
    repeat (3) tick();
    check("reset_decrypted", decrypted, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick();

    // Known-answer vectors, including parity-bit flips of the key.
    for (int i = 0; i < 5; i++)
      block_and_check($sformatf("kat%0d", i), vecs[i].msg, vecs[i].key, vecs[i].exp, 1'b0);

    // DONE holds without ack; enable pulses are ignored; enable with ack ignored.
    run_block(KAT_CT, KAT_KEY, 1'b0, held, lat);
    check("hold_first_data", held, KAT_PT);
    for (int i = 0; i < 10; i++) begin
      enable  = 1'(i & 1);
      message = {$urandom, $urandom};
      tick();
      check("hold_done", 64'(done), 64'd1);
      check("hold_data", decrypted, held);
    end
    enable = 1'b1;
    ack    = 1'b1;
    tick();
    enable = 1'b0;
    ack    = 1'b0;
    check("ack_with_enable_done", 64'(done), 64'd0);
    check("ack_with_enable_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("idle_keeps_data", decrypted, held);
    check("idle_stays_idle", 64'(busy), 64'd0);
    block_and_check("second_block", KAT_CT, KAT_KEY, KAT_PT, 1'b0);

    // Inputs churn every cycle after capture; result follows the captured pair.
    for (int i = 0; i < 4; i++) begin
      key = {$urandom, $urandom};
      ct  = {$urandom, $urandom};
      block_and_check("scramble", ct, key, m_des(ct, key, 1'b1), 1'b1);
    end

    // Abort mid-block with reset, then restart cleanly.
    message = KAT_CT; DESkey = KAT_KEY; enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (8) tick();
    reset = 1'b0;
    #1;
    check("abort_decrypted", decrypted, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("after_abort_idle", 64'(busy), 64'd0);
    block_and_check("after_abort", KAT_CT, KAT_KEY, KAT_PT, 1'b0);

    // Random round trips: model encrypts, DUT must recover the plaintext.
    for (int i = 0; i < 1000; i++) begin
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom};
      ct  = m_des(pt, key, 1'b0);
      run_block(ct, key, 1'b0, res, lat);
      check("roundtrip_latency", 64'(lat), 64'd17);
      check("roundtrip_data", res, pt);
      release_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
